// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode boundary: the packet record carried
// from fetch to decode and the canonical NOP used when decode sees nothing.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] ins_address;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] PCplus;
    logic            predicted;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// In-order decoupling queue between fetch and decode: absorbs decode stalls
// and drops every in-flight packet when a misprediction flush arrives.
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int size  = XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [size-1:0]          instruction_i,
  input  logic [size-1:0]          ins_address_i,
  input  logic [size-1:0]          imm_i,
  input  logic [size-1:0]          PCplus_i,
  input  logic                     predicted_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [size-1:0]          instruction_o,
  output logic [size-1:0]          ins_address_o,
  output logic [size-1:0]          imm_o,
  output logic [size-1:0]          PCplus_o,
  output logic                     predicted_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_packet_t   mem [DEPTH];
  fetch_packet_t   in_pkt;
  fetch_packet_t   head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count_o   = count;

  assign in_pkt = '{instruction: instruction_i, ins_address: ins_address_i,
                    imm: imm_i, PCplus: PCplus_i, predicted: predicted_i};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_pkt;
  end

  // Flush wins over both push and pop; count is kept apart from the
  // pointers so full and empty never alias.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    instruction_o = NOP_INSTR;
    ins_address_o = '0;
    imm_o         = '0;
    PCplus_o      = '0;
    predicted_o   = 1'b0;
    if (out_valid) begin
      instruction_o = head.instruction;
      ins_address_o = head.ins_address;
      imm_o         = head.imm;
      PCplus_o      = head.PCplus;
      predicted_o   = head.predicted;
    end
  end

endmodule
